// File: rtl/serial_receiver.sv
// serial_receiver
//   Receive side of the serial line. Hunts for an alternating preamble
//   (1010...10), shifts in a 24-bit header, validates it, then descrambles
//   the payload (x^7+x^4+1 additive scrambler) and emits bytes MSB first.
//
// Ports
//   Clock        in   rising-edge system clock
//   Reset        in   asynchronous, active-low reset
//   Input        in   serial line bit, sampled every rising edge
//   Output_Data  out  [7:0]  last descrambled byte (held between strobes)
//   Output_Valid out  one-cycle strobe, Output_Data valid
//   Frame_Start  out  one-cycle strobe, header accepted
//   Frame_End    out  one-cycle strobe, coincides with the last byte's Output_Valid
//   Header_Error out  one-cycle strobe, header rejected
//   Rate         out  [3:0]  rate field of the last accepted header
//   Length       out  [11:0] byte count of the last accepted header
//   Error_Count  out  [7:0]  (only with RX_ERROR_COUNT_EN) saturating count of
//                     header rejects and late preamble alternation breaks
//
// Build option: define RX_ERROR_COUNT_EN to add Error_Count.
// Header layout assumes HEADER_LEN = 24:
//   [23:20] rate, [19] reserved(0), [18:7] length, [6] even parity over [23:7],
//   [5:0] tail(0).

module serial_receiver #(
  parameter int unsigned PREAMBLE_LEN   = 96,
  parameter int unsigned HEADER_LEN     = 24,
  parameter logic [6:0]  SCRAMBLER_SEED = 7'b1011101
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Input,
  output logic [7:0]  Output_Data,
  output logic        Output_Valid,
  output logic        Frame_Start,
  output logic        Frame_End,
  output logic        Header_Error,
  output logic [3:0]  Rate,
  output logic [11:0] Length
`ifdef RX_ERROR_COUNT_EN
  ,
  output logic [7:0]  Error_Count
`endif
);

  localparam int unsigned PCW = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned HCW = $clog2(HEADER_LEN);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_PREAMBLE,
    ST_HEADER,
    ST_DATA
  } state_t;

  state_t                state_q, state_d;
  logic [PCW-1:0]        pcnt_q, pcnt_d;
  logic [HCW-1:0]        hcnt_q, hcnt_d;
  logic [HEADER_LEN-2:0] hdr_q, hdr_d;
  logic [6:0]            scr_q, scr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shreg_q, shreg_d;
  logic [11:0]           byte_cnt_q, byte_cnt_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  fstart_q, fstart_d;
  logic                  fend_q, fend_d;
  logic                  herr_q, herr_d;
  logic [3:0]            rate_q, rate_d;
  logic [11:0]           len_q, len_d;

  logic [HEADER_LEN-1:0] hdr_full;
  logic                  hdr_ok;
  logic                  hdr_done;
  logic                  brk;
  logic                  scr_f;
  logic                  dbit;

  assign hdr_full = {hdr_q, Input};
  assign hdr_ok   = (^hdr_full[23:6] == 1'b0) && !hdr_full[19] &&
                    (hdr_full[5:0] == 6'd0) && (hdr_full[18:7] != 12'd0);
  assign hdr_done = (state_q == ST_HEADER) && (hcnt_q == HCW'(HEADER_LEN - 1));
  // Odd counts end on a 1, so the expected next bit is the complement of pcnt_q[0].
  assign brk      = (state_q == ST_PREAMBLE) && (Input == pcnt_q[0]);
  assign scr_f    = scr_q[6] ^ scr_q[3];
  assign dbit     = Input ^ scr_f;

`ifdef RX_ERROR_COUNT_EN
  logic [7:0] errcnt_q, errcnt_d;
  logic       err_inc;

  assign err_inc     = (brk && (pcnt_q >= PCW'(16))) || (hdr_done && !hdr_ok);
  assign Error_Count = errcnt_q;
`endif

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    hcnt_d     = hcnt_q;
    hdr_d      = hdr_q;
    scr_d      = scr_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    fstart_d   = 1'b0;
    fend_d     = 1'b0;
    herr_d     = 1'b0;
    rate_d     = rate_q;
    len_d      = len_q;
`ifdef RX_ERROR_COUNT_EN
    errcnt_d   = (err_inc && (errcnt_q != 8'hFF)) ? errcnt_q + 8'd1 : errcnt_q;
`endif

    case (state_q)
      ST_HUNT: begin
        if (Input) begin
          pcnt_d  = PCW'(1);
          state_d = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        if (!brk) begin
          pcnt_d = pcnt_q + PCW'(1);
          if (pcnt_q == PCW'(PREAMBLE_LEN - 1)) begin
            hcnt_d  = '0;
            state_d = ST_HEADER;
          end
        end else if (Input) begin
          // A repeated 1 may be the first bit of a fresh preamble.
          pcnt_d = PCW'(1);
        end else begin
          pcnt_d  = '0;
          state_d = ST_HUNT;
        end
      end

      ST_HEADER: begin
        hdr_d  = hdr_full[HEADER_LEN-2:0];
        hcnt_d = hcnt_q + HCW'(1);
        // The check uses the just-sampled 24th bit so the verdict strobes
        // in the following cycle and payload bit 1 lands in DATA.
        if (hdr_done) begin
          hcnt_d = '0;
          if (hdr_ok) begin
            rate_d     = hdr_full[23:20];
            len_d      = hdr_full[18:7];
            fstart_d   = 1'b1;
            scr_d      = SCRAMBLER_SEED;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            state_d    = ST_DATA;
          end else begin
            herr_d  = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end

      ST_DATA: begin
        scr_d     = {scr_q[5:0], scr_f};
        shreg_d   = {shreg_q[5:0], dbit};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_d     = {shreg_q, dbit};
          valid_d    = 1'b1;
          byte_cnt_d = byte_cnt_q + 12'd1;
          // Compare before increment so Length=4095 ends without wrapping.
          if (byte_cnt_q + 12'd1 == len_q) begin
            fend_d  = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_HUNT;
      pcnt_q     <= '0;
      hcnt_q     <= '0;
      hdr_q      <= '0;
      scr_q      <= SCRAMBLER_SEED;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fstart_q   <= 1'b0;
      fend_q     <= 1'b0;
      herr_q     <= 1'b0;
      rate_q     <= '0;
      len_q      <= '0;
`ifdef RX_ERROR_COUNT_EN
      errcnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      hcnt_q     <= hcnt_d;
      hdr_q      <= hdr_d;
      scr_q      <= scr_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fstart_q   <= fstart_d;
      fend_q     <= fend_d;
      herr_q     <= herr_d;
      rate_q     <= rate_d;
      len_q      <= len_d;
`ifdef RX_ERROR_COUNT_EN
      errcnt_q   <= errcnt_d;
`endif
    end
  end

  assign Output_Data  = data_q;
  assign Output_Valid = valid_q;
  assign Frame_Start  = fstart_q;
  assign Frame_End    = fend_q;
  assign Header_Error = herr_q;
  assign Rate         = rate_q;
  assign Length       = len_q;

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
Receive-side counterpart of the serial Transmitter. Consumes the 1-bit-per-clock line stream: alternating preamble, then a 24-bit unscrambled header, then scrambled payload. Locks on the preamble, parses and checks the header, descrambles the payload, and emits bytes with a one-cycle valid strobe. Sits between the line input and the MAC-side byte consumer.

Parameters:
PREAMBLE_LEN, 96, number of alternating bits (starting 1, ending 0) required for lock
HEADER_LEN, 24, header bits after preamble (fixed field layout below)
SCRAMBLER_SEED, 7'b1011101, descrambler state loaded at payload start

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Input  input  1  serial line bit, sampled every rising edge
Output_Data  output  8  descrambled payload byte, MSB = first received bit
Output_Valid  output  1  one-cycle strobe, Output_Data valid
Frame_Start  output  1  one-cycle strobe, header accepted
Frame_End  output  1  one-cycle strobe, coincident with last byte's Output_Valid
Header_Error  output  1  one-cycle strobe, header rejected
Rate  output  4  header rate field, held until next accepted header
Length  output  12  header payload byte count, held until next accepted header

Behaviour:
- Reset (asynchronous, active-low) forces state HUNT. All outputs are 0. Bit counters are 0. Descrambler is SCRAMBLER_SEED. Reset asserted mid-frame discards the frame and emits no strobes.
- HUNT: wait for Input=1. That bit is preamble bit 1 and sets the alternation count to 1. Go to PREAMBLE.
- PREAMBLE: each bit must be the complement of the previous bit.
  - A correct bit increments the count.
  - An alternation break with Input=1 restarts the count at 1 and stays in PREAMBLE.
  - An alternation break with Input=0 returns to HUNT.
  - When the count reaches PREAMBLE_LEN (last bit 0), enter HEADER on the next clock.
- HEADER: shift HEADER_LEN bits, MSB first. Field layout:
  - bits 23:20 = rate
  - bit 19 = reserved (must be 0)
  - bits 18:7 = length
  - bit 6 = even parity over bits 23:7
  - bits 5:0 = tail (must be 0)
- Header check, performed in the cycle after the 24th bit:
  - Accept when parity is even, reserved=0, tail=0 and length != 0. Register Rate and Length, pulse Frame_Start, load the descrambler with SCRAMBLER_SEED, and enter DATA.
  - Otherwise pulse Header_Error, leave Rate and Length unchanged, and return to HUNT.
- DATA: descrambler polynomial x^7+x^4+1, state s[6:0].
  - f = s[6]^s[3]
  - descrambled bit = Input^f
  - next s = {s[5:0], f}
  - Bits are assembled MSB first. After the 8th bit of a byte, Output_Data and Output_Valid are presented on the next clock (latency 1).
  - Byte counter is 12 bits. When the byte count equals Length, Frame_End pulses with that Output_Valid and the state returns to HUNT.
  - The first bit of a new preamble may arrive on the clock immediately after the last payload bit and must be accepted.
- Output_Data holds its last value between strobes. Strobes never assert together, except Output_Valid with Frame_End.
- Input is ignored in DATA for preamble purposes; there is no re-lock mid-frame.
- Length=4095 is legal. The byte counter must not wrap before the end is detected.

Optional Feature:
RX_ERROR_COUNT_EN
- Defined: adds output Error_Count[7:0], reset to 0.
  - Increments on each Header_Error pulse and on each preamble alternation break occurring after count >= 16.
  - Saturates at 255.
  - Cleared only by Reset.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Idle zeros, then 96-bit 1010..10 preamble, header rate=4'b1101, length=1, valid parity, tail=0, then the byte 8'hA5 scrambled by the bench model seeded 7'b1011101 -> Frame_Start one cycle after header bit 24; Output_Valid with Output_Data=8'hA5 and Frame_End together; Rate=4'hD, Length=12'd1.
- Same frame with the header parity bit flipped -> Header_Error single pulse; no Frame_Start, no Output_Valid; Rate/Length keep their prior values; a following good frame decodes normally.
- Preamble broken at bit 40 by "11", then a full 96-bit preamble and a good 3-byte frame (8'h00, 8'hFF, 8'h3C) -> lock from the restarted 1; three Output_Valid strobes with the correct bytes; Frame_End on the third.
- Reset driven low for 2 ns during DATA of a 4-byte frame -> all outputs 0 immediately; no further strobes; a subsequent good frame is received correctly.
- Two back-to-back frames with no idle gap (length=2, then length=1) -> 3 bytes total; two Frame_Start and two Frame_End pulses; descrambler reseeded for the second frame.
- With RX_ERROR_COUNT_EN defined: 3 bad-tail headers -> Error_Count=3; 300 bad headers -> Error_Count=255.
